// File: rtl/stopwatch_pkg.sv
// Shared stopwatch encodings: control-FSM status values, press-FSM states
// and the command selected by a short start/stop press.
package stopwatch_pkg;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_RUNNING = 2'b01;
  localparam logic [1:0] ST_PAUSED  = 2'b10;

  typedef enum logic [1:0] {
    PR_UP      = 2'b00,
    PR_PRESSED = 2'b01,
    PR_HELD    = 2'b10
  } press_state_e;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'b00,
    CMD_START = 2'b01,
    CMD_STOP  = 2'b10,
    CMD_RESET = 2'b11
  } cmd_e;

  // A short press toggles run state; an invalid status yields nothing.
  function automatic cmd_e short_press_cmd(input logic [1:0] st);
    cmd_e c;
    case (st)
      ST_IDLE, ST_PAUSED: c = CMD_START;
      ST_RUNNING:         c = CMD_STOP;
      default:            c = CMD_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus stable-count debouncer for one raw button.
// flip pulses for one cycle in the same cycle the debounced level changes.
module btn_debounce #(
  parameter int DEB_CYC = 16,
  parameter int CNT_W   = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic flip
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             level_r;
  logic             flip_r;
  logic [CNT_W-1:0] cnt_r;

  // Synchronize, then accept a new level only after DEB_CYC mismatching cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      level_r <= 1'b0;
      flip_r  <= 1'b0;
      cnt_r   <= '0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
      flip_r  <= 1'b0;
      if (sync2_r != level_r) begin
        if (cnt_r == CNT_LAST) begin
          level_r <= sync2_r;
          flip_r  <= 1'b1;
          cnt_r   <= '0;
        end else begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
      end else begin
        cnt_r <= '0;
      end
    end
  end

  assign level = level_r;
  assign flip  = flip_r;

endmodule

// File: rtl/stopwatch_cmd_sequencer.sv
// Turns the start/stop and reset buttons into one-cycle start/stop/reset pulses.
// Defining CMD_EVENT_CNT_EN adds the cmd_count output (wrapping command counter).
module stopwatch_cmd_sequencer
  import stopwatch_pkg::*;
#(
  parameter int DEB_CYC  = 16,
  parameter int LONG_CYC = 1000,
  parameter int CNT_W    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_ss_raw,
  input  logic       btn_rst_raw,
  input  logic [1:0] status,
  output logic       start,
  output logic       stop,
  output logic       reset
`ifdef CMD_EVENT_CNT_EN
  ,
  output logic [7:0] cmd_count
`endif
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);

  logic             ss_level_s;
  logic             ss_flip_s;
  logic             rst_level_s;
  logic             rst_flip_s;
  logic             ss_rise_s;
  logic             ss_fall_s;
  logic             rst_rise_s;
  press_state_e     state_r;
  press_state_e     state_s;
  logic [CNT_W-1:0] hold_r;
  logic [CNT_W-1:0] hold_s;
  cmd_e             press_cmd_s;
  cmd_e             cmd_s;

  btn_debounce #(.DEB_CYC(DEB_CYC), .CNT_W(CNT_W)) u_deb_ss (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_ss_raw),
    .level (ss_level_s),
    .flip  (ss_flip_s)
  );

  btn_debounce #(.DEB_CYC(DEB_CYC), .CNT_W(CNT_W)) u_deb_rst (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_rst_raw),
    .level (rst_level_s),
    .flip  (rst_flip_s)
  );

  assign ss_rise_s  = ss_flip_s & ss_level_s;
  assign ss_fall_s  = ss_flip_s & ~ss_level_s;
  assign rst_rise_s = rst_flip_s & rst_level_s;

  // Press FSM: hold_r is 0 in the rise cycle and counts cycles since then.
  always_comb begin
    state_s     = state_r;
    hold_s      = hold_r;
    press_cmd_s = CMD_NONE;
    case (state_r)
      PR_UP: begin
        hold_s = '0;
        if (ss_rise_s) begin
          state_s = PR_PRESSED;
          hold_s  = CNT_W'(1);
        end else begin
          state_s = PR_UP;
        end
      end
      PR_PRESSED: begin
        hold_s = hold_r + CNT_W'(1);
        if (ss_fall_s) begin
          state_s     = PR_UP;
          hold_s      = '0;
          press_cmd_s = short_press_cmd(status);
        end else if (hold_r == LONG_LAST) begin
          state_s     = PR_HELD;
          press_cmd_s = CMD_RESET;
        end else if (rst_rise_s) begin
          state_s = PR_HELD;
        end else begin
          state_s = PR_PRESSED;
        end
      end
      PR_HELD: begin
        if (ss_fall_s) begin
          state_s = PR_UP;
        end else begin
          state_s = PR_HELD;
        end
      end
      default: begin
        state_s = PR_UP;
        hold_s  = '0;
      end
    endcase
    if (rst_rise_s) begin
      cmd_s = CMD_RESET;
    end else begin
      cmd_s = press_cmd_s;
    end
  end

  // State, hold counter and one-hot registered command outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= PR_UP;
      hold_r  <= '0;
      start   <= 1'b0;
      stop    <= 1'b0;
      reset   <= 1'b0;
    end else begin
      state_r <= state_s;
      hold_r  <= hold_s;
      start   <= (cmd_s == CMD_START);
      stop    <= (cmd_s == CMD_STOP);
      reset   <= (cmd_s == CMD_RESET);
    end
  end

`ifdef CMD_EVENT_CNT_EN
  // Wrapping count of issued command pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_count <= 8'd0;
    end else if (start | stop | reset) begin
      cmd_count <= cmd_count + 8'd1;
    end else begin
      cmd_count <= cmd_count;
    end
  end
`endif

endmodule

// File: tb/tb_stopwatch_cmd_sequencer.sv
// Randomized self-checking bench for stopwatch_cmd_sequencer (DEB_CYC=4, LONG_CYC=20)
// against an event-level reference model built from button history windows.
module tb_stopwatch_cmd_sequencer;

  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int HMAX = 16384;

  logic       clk;
  logic       rst_n;
  logic       btn_ss_raw;
  logic       btn_rst_raw;
  logic [1:0] status;
  logic       start;
  logic       stop;
  logic       reset;
`ifdef CMD_EVENT_CNT_EN
  logic [7:0] cmd_count;
`endif

  stopwatch_cmd_sequencer #(.DEB_CYC(DEB), .LONG_CYC(LONG), .CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_ss_raw  (btn_ss_raw),
    .btn_rst_raw (btn_rst_raw),
    .status      (status),
    .start       (start),
    .stop        (stop),
    .reset       (reset)
`ifdef CMD_EVENT_CNT_EN
    ,
    .cmd_count   (cmd_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: synced-button history, debounced levels, press tracking.
  int       cyc = 0;
  bit       ss_raw_h  [HMAX];
  bit       rst_raw_h [HMAX];
  bit       ss_s_h    [HMAX];
  bit       rst_s_h   [HMAX];
  bit       db_ss, db_rst;
  int       lf_ss, lf_rst;
  bit       ev_ss_rise, ev_ss_fall, ev_rst_rise;
  bit       press_active, suppressed;
  int       press_start;
  bit [2:0] exp_now;   // {reset, stop, start}
  int       exp_pulses;

  // Level flips at edge n when the synced value disagreed for the last DEB cycles.
  function automatic bit window_flip(input int n, input bit is_ss, input bit db, input int lf);
    if (n - DEB < lf) return 1'b0;
    for (int k = 1; k <= DEB; k++) begin
      if ((is_ss ? ss_s_h[n-k] : rst_s_h[n-k]) == db) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic bit [2:0] short_cmd(input bit [1:0] st);
    if (st == 2'b01) return 3'b010;
    if (st == 2'b11) return 3'b000;
    return 3'b001;
  endfunction

  // One clock: drive inputs, decide this cycle's command, then advance the model past the edge.
  task automatic tick(input bit ss, input bit rb, input bit rn);
    bit [2:0] cmd;
    bit f;
    btn_ss_raw  = ss;
    btn_rst_raw = rb;
    rst_n       = rn;
    cmd = 3'b000;
    if (ev_rst_rise) begin
      cmd = 3'b100;
      if (press_active && !suppressed && !ev_ss_fall) suppressed = 1'b1;
    end
    if (!press_active) begin
      if (ev_ss_rise) begin
        press_active = 1'b1;
        suppressed   = 1'b0;
        press_start  = cyc;
      end
    end else if (suppressed) begin
      if (ev_ss_fall) press_active = 1'b0;
    end else if (ev_ss_fall) begin
      press_active = 1'b0;
      if (!ev_rst_rise) cmd = short_cmd(status);
    end else if (cyc - press_start == LONG - 1) begin
      suppressed = 1'b1;
      cmd = 3'b100;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!rn) begin
      ss_raw_h[cyc] = 1'b0; rst_raw_h[cyc] = 1'b0;
      ss_s_h[cyc]   = 1'b0; rst_s_h[cyc]   = 1'b0;
      db_ss = 1'b0; db_rst = 1'b0; lf_ss = cyc; lf_rst = cyc;
      ev_ss_rise = 1'b0; ev_ss_fall = 1'b0; ev_rst_rise = 1'b0;
      press_active = 1'b0; suppressed = 1'b0;
      exp_now = 3'b000; exp_pulses = 0;
    end else begin
      exp_now = cmd;
      if (cmd != 3'b000) exp_pulses++;
      ss_raw_h[cyc]  = ss;
      rst_raw_h[cyc] = rb;
      ss_s_h[cyc]    = ss_raw_h[cyc-1];
      rst_s_h[cyc]   = rst_raw_h[cyc-1];
      f = window_flip(cyc, 1'b1, db_ss, lf_ss);
      if (f) begin db_ss = ~db_ss; lf_ss = cyc; end
      ev_ss_rise = f & db_ss;
      ev_ss_fall = f & ~db_ss;
      f = window_flip(cyc, 1'b0, db_rst, lf_rst);
      if (f) begin db_rst = ~db_rst; lf_rst = cyc; end
      ev_rst_rise = f & db_rst;
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 8; c++) begin
      tick(1'($urandom), 1'($urandom), 1'b0);
      vectors++;
      if ({reset, stop, start} !== 3'b000) begin
        $display("FAIL reset cyc=%0d got=%b expected=000", cyc, {reset, stop, start});
        miscompares++;
      end
    end
    for (int c = 0; c < 12; c++) begin
      tick(1'b0, 1'b0, 1'b1);
      vectors++;
      if ({reset, stop, start} !== exp_now) begin
        $display("FAIL reset_idle cyc=%0d got=%b expected=%b", cyc, {reset, stop, start}, exp_now);
        miscompares++;
      end
    end
  endtask

  task automatic test_short_press();
    bit [1:0] st_tab [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    for (int i = 0; i < 4; i++) begin
      int hold = int'($urandom_range(8, 12));
      int n_start = 0, n_stop = 0, n_reset = 0, r_cyc = 0, hit_cyc = -1;
      status = st_tab[i];
      for (int c = 0; c < 10 + hold + 30; c++) begin
        if (c == 10 + hold) r_cyc = cyc;
        tick(c >= 10 && c < 10 + hold, 1'b0, 1'b1);
        vectors++;
        if ({reset, stop, start} !== exp_now) begin
          $display("FAIL short_press st=%b cyc=%0d got=%b expected=%b", st_tab[i], cyc, {reset, stop, start}, exp_now);
          miscompares++;
        end
        n_start += int'(start); n_stop += int'(stop); n_reset += int'(reset);
        if (start | stop) hit_cyc = cyc;
      end
      vectors++;
      if (n_start != ((st_tab[i] == 2'b00 || st_tab[i] == 2'b10) ? 1 : 0) ||
          n_stop != ((st_tab[i] == 2'b01) ? 1 : 0) || n_reset != 0) begin
        $display("FAIL short_count st=%b got start=%0d stop=%0d reset=%0d", st_tab[i], n_start, n_stop, n_reset);
        miscompares++;
      end
      if (st_tab[i] != 2'b11) begin
        vectors++;
        if (hit_cyc != r_cyc + 7) begin
          $display("FAIL short_latency st=%b got cyc=%0d expected cyc=%0d", st_tab[i], hit_cyc, r_cyc + 7);
          miscompares++;
        end
      end
    end
  endtask

  task automatic test_long_press();
    int n_ss = 0, n_reset = 0, r_cyc = 0, hit_cyc = -1;
    status = 2'($urandom_range(0, 2));
    for (int c = 0; c < 80; c++) begin
      if (c == 5) r_cyc = cyc;
      tick(c >= 5 && c < 45, 1'b0, 1'b1);
      vectors++;
      if ({reset, stop, start} !== exp_now) begin
        $display("FAIL long_press cyc=%0d got=%b expected=%b", cyc, {reset, stop, start}, exp_now);
        miscompares++;
      end
      n_ss += int'(start) + int'(stop);
      n_reset += int'(reset);
      if (reset) hit_cyc = cyc;
    end
    vectors++;
    if (n_reset != 1 || n_ss != 0 || hit_cyc != r_cyc + DEB + 2 + LONG) begin
      $display("FAIL long_press_sum got reset=%0d start_stop=%0d at cyc=%0d expected 1/0 at %0d",
               n_reset, n_ss, hit_cyc, r_cyc + DEB + 2 + LONG);
      miscompares++;
    end
  endtask

  task automatic test_bounce();
    int n_any = 0;
    status = 2'b00;
    for (int c = 0; c < 50; c++) begin
      tick(c < 30 && ((c / 2) % 2 == 1), c < 30 && ($urandom_range(0, 3) == 0), 1'b1);
      vectors++;
      if ({reset, stop, start} !== exp_now) begin
        $display("FAIL bounce cyc=%0d got=%b expected=%b", cyc, {reset, stop, start}, exp_now);
        miscompares++;
      end
      n_any += int'(start) + int'(stop) + int'(reset);
    end
    vectors++;
    if (n_any != 0) begin
      $display("FAIL bounce_sum got pulses=%0d expected 0", n_any);
      miscompares++;
    end
  endtask

  task automatic test_rst_button();
    int n_ss = 0, n_reset = 0;
    status = 2'($urandom_range(0, 2));
    for (int c = 0; c < 60; c++) begin
      tick(c < 25, c >= 5 && c < 25, 1'b1);
      vectors++;
      if ({reset, stop, start} !== exp_now) begin
        $display("FAIL rst_button cyc=%0d got=%b expected=%b", cyc, {reset, stop, start}, exp_now);
        miscompares++;
      end
      n_ss += int'(start) + int'(stop);
      n_reset += int'(reset);
    end
    for (int c = 0; c < 50; c++) begin
      tick(c < 12, c >= 12 && c < 22, 1'b1);
      vectors++;
      if ({reset, stop, start} !== exp_now) begin
        $display("FAIL rst_coincident cyc=%0d got=%b expected=%b", cyc, {reset, stop, start}, exp_now);
        miscompares++;
      end
      n_ss += int'(start) + int'(stop);
      n_reset += int'(reset);
    end
    vectors++;
    if (n_reset != 2 || n_ss != 0) begin
      $display("FAIL rst_button_sum got reset=%0d start_stop=%0d expected 2/0", n_reset, n_ss);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid();
    int n_start = 0, n_other = 0;
    status = 2'b00;
    for (int c = 0; c < 50; c++) begin
      tick(c < 30, 1'b0, !(c >= 10 && c < 15));
      vectors++;
      if ({reset, stop, start} !== exp_now) begin
        $display("FAIL reset_mid cyc=%0d got=%b expected=%b", cyc, {reset, stop, start}, exp_now);
        miscompares++;
      end
      if (c >= 15) begin
        n_start += int'(start);
        n_other += int'(stop) + int'(reset);
      end
    end
    vectors++;
    if (n_start != 1 || n_other != 0) begin
      $display("FAIL reset_mid_sum got start=%0d other=%0d expected 1/0", n_start, n_other);
      miscompares++;
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 60; s++) begin
      int len = int'($urandom_range(1, 30));
      bit ss = 1'($urandom);
      bit rb = ($urandom_range(0, 3) == 0);
      status = 2'($urandom);
      for (int c = 0; c < len; c++) begin
        tick(ss, rb, 1'b1);
        vectors++;
        if ({reset, stop, start} !== exp_now) begin
          $display("FAIL random cyc=%0d got=%b expected=%b", cyc, {reset, stop, start}, exp_now);
          miscompares++;
        end
      end
    end
  endtask

`ifdef CMD_EVENT_CNT_EN
  task automatic test_cmd_count();
    for (int c = 0; c < 3; c++) tick(1'b0, 1'b0, 1'b0);
    for (int p = 0; p < 256; p++) begin
      for (int c = 0; c < 14; c++) begin
        tick(1'b0, c < 7, 1'b1);
        vectors++;
        if ({reset, stop, start} !== exp_now) begin
          $display("FAIL cmd_count_pulse cyc=%0d got=%b expected=%b", cyc, {reset, stop, start}, exp_now);
          miscompares++;
        end
      end
    end
    for (int c = 0; c < 3; c++) tick(1'b0, 1'b0, 1'b1);
    vectors++;
    if (cmd_count !== 8'(exp_pulses)) begin
      $display("FAIL cmd_count_wrap got=%0d expected=%0d", cmd_count, 8'(exp_pulses));
      miscompares++;
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0; btn_ss_raw = 1'b0; btn_rst_raw = 1'b0; status = 2'b00;
    exp_now = 3'b000; exp_pulses = 0;
    test_reset();
    test_short_press();
    test_long_press();
    test_bounce();
    test_rst_button();
    test_reset_mid();
    test_random();
`ifdef CMD_EVENT_CNT_EN
    test_cmd_count();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
